// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder:
// MDOp encodings, FSM state encodings and the default data width.
package mult_div_unit_pkg;

  localparam int unsigned MD_DATA_W = 32;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } md_state_e;

endpackage

// File: rtl/mult_div_unit_md_step.sv
// One radix-2 iteration of the multiply/divide datapath (combinational).
//   acc, shreg : current partial result (high / low halves)
//   operand    : multiplicand or divisor (magnitude)
//   is_div     : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_nxt, shreg_nxt : next partial result
// Multiply: shreg holds the multiplier, consumed LSB first; the product
//   shifts right into shreg. Divide: shreg holds the dividend, consumed MSB
//   first; quotient bits shift in at the LSB, acc holds the remainder.
module mult_div_unit_md_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] shreg,
  input  logic [W-1:0] operand,
  input  logic         is_div,
  output logic [W-1:0] acc_nxt,
  output logic [W-1:0] shreg_nxt
);

  logic [W:0] sum;
  logic [W:0] shifted;
  logic       ge;

  always_comb begin
    sum     = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);
    shifted = {acc, shreg[W-1]};
    ge      = (shifted >= {1'b0, operand});
    if (is_div) begin
      // remainder stays below the divisor, so the difference fits in W bits
      acc_nxt   = ge ? (shifted[W-1:0] - operand) : shifted[W-1:0];
      shreg_nxt = {shreg[W-2:0], ge};
    end else begin
      acc_nxt   = sum[W:1];
      shreg_nxt = {sum[0], shreg[W-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Handles MULT, MULTU, DIV, DIVU (DATA_W+1 busy cycles) and MTHI/MTLO
// (written at the issue edge, no busy).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   MDStart, MDOp      issue request and operation (sampled while idle)
//   MDOpX, MDOpY       rs / rt operands
//   MDBusy             operation in flight
//   MDDone             one-cycle pulse when new HI/LO become visible
//   MDDivZero          divide-by-zero flag alongside MDDone
//   HI, LO             architectural HI/LO registers
// Build option MD_DIVZERO_FAST_EN: divide by zero finishes after one busy
// cycle and raises MDDivZero; otherwise it runs the full length and
// MDDivZero stays 0. HI/LO results are the same either way.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned DATA_W = MD_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MDStart,
  input  logic [2:0]        MDOp,
  input  logic [DATA_W-1:0] MDOpX,
  input  logic [DATA_W-1:0] MDOpY,
  output logic              MDBusy,
  output logic              MDDone,
  output logic              MDDivZero,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  md_state_e           state;
  logic [CNT_W-1:0]    count;
  logic [DATA_W-1:0]   acc, shreg, operand;
  logic                is_div, neg_hi, neg_lo;
  logic [DATA_W-1:0]   acc_nxt, shreg_nxt;

  logic                op_mul, op_div, op_signed, x_neg, y_neg, y_zero;
  logic [DATA_W-1:0]   abs_x, abs_y;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   hi_fix, lo_fix;

  mult_div_unit_md_step #(.W(DATA_W)) u_step (
    .acc       (acc),
    .shreg     (shreg),
    .operand   (operand),
    .is_div    (is_div),
    .acc_nxt   (acc_nxt),
    .shreg_nxt (shreg_nxt)
  );

  always_comb begin
    op_mul    = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
    op_div    = (MDOp == MD_DIV)  || (MDOp == MD_DIVU);
    op_signed = (MDOp == MD_MULT) || (MDOp == MD_DIV);
    x_neg     = op_signed & MDOpX[DATA_W-1];
    y_neg     = op_signed & MDOpY[DATA_W-1];
    y_zero    = op_div && (MDOpY == '0);
    abs_x     = x_neg ? -MDOpX : MDOpX;
    abs_y     = y_neg ? -MDOpY : MDOpY;
  end

  // Sign correction: whole 2W-bit product for multiply, separate
  // quotient/remainder negation for divide.
  always_comb begin
    prod_fix = neg_lo ? -{acc, shreg} : {acc, shreg};
    hi_fix   = prod_fix[2*DATA_W-1:DATA_W];
    lo_fix   = prod_fix[DATA_W-1:0];
    if (is_div) begin
      hi_fix = neg_hi ? -acc : acc;
      lo_fix = neg_lo ? -shreg : shreg;
    end
  end

`ifdef MD_DIVZERO_FAST_EN
  logic divzero;
`else
  assign MDDivZero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      acc     <= '0;
      shreg   <= '0;
      operand <= '0;
      is_div  <= 1'b0;
      neg_hi  <= 1'b0;
      neg_lo  <= 1'b0;
      MDBusy  <= 1'b0;
      MDDone  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
`ifdef MD_DIVZERO_FAST_EN
      divzero   <= 1'b0;
      MDDivZero <= 1'b0;
`endif
    end else begin
      MDDone <= 1'b0;
`ifdef MD_DIVZERO_FAST_EN
      MDDivZero <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (MDStart) begin
            if (op_mul || op_div) begin
              MDBusy  <= 1'b1;
              count   <= '0;
              is_div  <= op_div;
              operand <= abs_y;
`ifdef MD_DIVZERO_FAST_EN
              divzero <= y_zero;
`endif
              if (y_zero) begin
                // Zero divisor: raw dividend, no sign fix. An unsigned walk
                // with divisor 0 ends with acc=dividend, shreg=all ones.
                neg_hi <= 1'b0;
                neg_lo <= 1'b0;
`ifdef MD_DIVZERO_FAST_EN
                acc   <= MDOpX;
                shreg <= '1;
                state <= S_FIX;
`else
                acc   <= '0;
                shreg <= MDOpX;
                state <= S_RUN;
`endif
              end else begin
                acc    <= '0;
                shreg  <= abs_x;
                neg_hi <= op_div & x_neg;
                neg_lo <= x_neg ^ y_neg;
                state  <= S_RUN;
              end
            end else if (MDOp == MD_MTHI) begin
              HI <= MDOpX;
            end else if (MDOp == MD_MTLO) begin
              LO <= MDOpX;
            end
          end
        end
        S_RUN: begin
          acc   <= acc_nxt;
          shreg <= shreg_nxt;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(DATA_W - 1)) state <= S_FIX;
        end
        S_FIX: begin
          HI     <= hi_fix;
          LO     <= lo_fix;
          MDBusy <= 1'b0;
          MDDone <= 1'b1;
`ifdef MD_DIVZERO_FAST_EN
          MDDivZero <= divzero;
`endif
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                         OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;
`ifdef MD_DIVZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MDStart = 1'b0;
  logic [2:0]  MDOp = 3'd0;
  logic [31:0] MDOpX = '0, MDOpY = '0;
  logic        MDBusy, MDDone, MDDivZero;
  logic [31:0] HI, LO;

  mult_div_unit #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .MDStart   (MDStart),
    .MDOp      (MDOp),
    .MDOpX     (MDOpX),
    .MDOpY     (MDOpY),
    .MDBusy    (MDBusy),
    .MDDone    (MDDone),
    .MDDivZero (MDDivZero),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference result {divzero, hi, lo} from plain arithmetic.
  function automatic logic [64:0] ref_md(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint unsigned up;
    longint          sp;
    int              sx, sy;
    sx = x;
    sy = y;
    ref_md = '0;
    case (op)
      OP_MULTU: begin
        up = longint'({32'b0, x}) * longint'({32'b0, y});
        ref_md = {1'b0, up};
      end
      OP_MULT: begin
        sp = longint'(sx) * longint'(sy);
        ref_md = {1'b0, sp};
      end
      OP_DIVU: begin
        if (y == 0) ref_md = {1'b1, x, 32'hFFFF_FFFF};
        else        ref_md = {1'b0, x % y, x / y};
      end
      OP_DIV: begin
        if (y == 0) ref_md = {1'b1, x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ref_md = {1'b0, 32'h0, x};
        else ref_md = {1'b0, 32'(sx % sy), 32'(sx / sy)};
      end
      default: ref_md = '0;
    endcase
  endfunction

  // Transaction-level model: HI/LO plus a countdown of remaining busy cycles.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  int          left = 0;

  always @(posedge clk) begin
    logic [64:0] r;
    if (rst) begin
      m_hi = '0; m_lo = '0; left = 0; m_done = 1'b0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dz = p_dz & FAST;
        end
      end else if (MDStart) begin
        if (MDOp >= OP_MULT && MDOp <= OP_DIVU) begin
          r = ref_md(MDOp, MDOpX, MDOpY);
          p_dz = r[64]; p_hi = r[63:32]; p_lo = r[31:0];
          left = (FAST && r[64]) ? 1 : 33;
        end else if (MDOp == OP_MTHI) m_hi = MDOpX;
        else if (MDOp == OP_MTLO) m_lo = MDOpX;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(MDBusy), 64'(left != 0));
      chk("done", 64'(MDDone), 64'(m_done));
      chk("divzero", 64'(MDDivZero), 64'(m_dz));
      chk("hi", 64'(HI), 64'(m_hi));
      chk("lo", 64'(LO), 64'(m_lo));
    end
  end

  task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    MDStart = st; MDOp = op; MDOpX = x; MDOpY = y;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    drive(1'b1, op, x, y);
    drive(1'b0, 3'($urandom), $urandom, $urandom);
  endtask

  // Returns busy cycles seen; stops on the MDDone cycle, bounded.
  task automatic wait_done(output int busy_cycles);
    bit seen;
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (MDBusy) busy_cycles++;
      if (MDDone) begin
        seen = 1'b1;
        break;
      end
      drive(1'b0, 3'd0, $urandom, $urandom);
    end
    if (!seen) chk("done_timeout", 64'(0), 64'(1));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: pick = 32'h0;
      1: pick = 32'h8000_0000;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'($urandom_range(0, 15));
      4: pick = -32'($urandom_range(1, 15));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    int bc;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_hi", 64'(HI), 64'h0);
    chk("reset_lo", 64'(LO), 64'h0);
    chk("reset_busy", 64'(MDBusy), 64'h0);
    rst = 1'b0;

    // 1: largest unsigned product, latency
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc);
    chk("t1_busy_len", 64'(bc), 64'd33);
    chk("t1_hi", 64'(HI), 64'hFFFF_FFFE);
    chk("t1_lo", 64'(LO), 64'h0000_0001);
    drive(1'b0, 3'd0, '0, '0);
    chk("t1_done_pulse", 64'(MDDone), 64'h0);

    // 2: signed multiply and divide
    issue(OP_MULT, -32'sd3, 32'd5);
    wait_done(bc);
    chk("t2_mult_hi", 64'(HI), 64'hFFFF_FFFF);
    chk("t2_mult_lo", 64'(LO), 64'hFFFF_FFF1);
    issue(OP_DIV, -32'sd7, 32'd2);
    wait_done(bc);
    chk("t2_div_lo", 64'(LO), 64'hFFFF_FFFD);
    chk("t2_div_hi", 64'(HI), 64'hFFFF_FFFF);

    // 3: overflow wrap and divide by zero
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(bc);
    chk("t3_ovf_lo", 64'(LO), 64'h8000_0000);
    chk("t3_ovf_hi", 64'(HI), 64'h0);
    chk("t3_ovf_dz", 64'(MDDivZero), 64'h0);
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_done(bc);
    chk("t3_dz_lo", 64'(LO), 64'hFFFF_FFFF);
    chk("t3_dz_hi", 64'(HI), 64'h7);
    chk("t3_dz_flag", 64'(MDDivZero), 64'(FAST));
    chk("t3_dz_busy_len", 64'(bc), FAST ? 64'd1 : 64'd33);
    issue(OP_DIV, 32'hFFFF_FFF0, 32'd0);
    wait_done(bc);
    chk("t3_sdz_hi", 64'(HI), 64'hFFFF_FFF0);
    chk("t3_sdz_lo", 64'(LO), 64'hFFFF_FFFF);

    // 4: starts while busy are ignored
    issue(OP_MULTU, 32'd2, 32'd3);
    repeat (3) drive(1'b0, 3'd0, '0, '0);
    issue(OP_DIVU, 32'd9, 32'd4);
    issue(OP_MTLO, 32'h55, 32'd0);
    wait_done(bc);
    chk("t4_hi", 64'(HI), 64'h0);
    chk("t4_lo", 64'(LO), 64'h6);
    repeat (2) drive(1'b0, 3'd0, '0, '0);
    chk("t4_no_queue", 64'(MDBusy), 64'h0);

    // 5: back-to-back moves
    drive(1'b1, OP_MTHI, 32'h1234, 32'd0);
    drive(1'b1, OP_MTLO, 32'h5678, 32'd0);
    chk("t5_hi", 64'(HI), 64'h1234);
    chk("t5_busy0", 64'(MDBusy), 64'h0);
    drive(1'b0, 3'd0, '0, '0);
    chk("t5_lo", 64'(LO), 64'h5678);
    chk("t5_busy1", 64'(MDBusy), 64'h0);

    // 6: reset aborts an operation in flight
    issue(OP_DIVU, 32'd1000, 32'd7);
    repeat (8) drive(1'b0, 3'd0, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", 64'(MDBusy), 64'h0);
    chk("t6_hi", 64'(HI), 64'h0);
    chk("t6_lo", 64'(LO), 64'h0);
    chk("t6_done", 64'(MDDone), 64'h0);
    rst = 1'b0;
    issue(OP_MULT, 32'd4, -32'sd2);
    wait_done(bc);
    chk("t6_mult_lo", 64'(LO), 64'hFFFF_FFF8);
    chk("t6_mult_hi", 64'(HI), 64'hFFFF_FFFF);

    // Random traffic, including starts while busy and invalid ops
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), pick(), pick());
    end
    for (int i = 0; i < 40; i++) drive(1'b0, 3'd0, '0, '0);
    chk("final_idle", 64'(MDBusy), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
